// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size codes, FSM states and word-index width shared by the load/store unit.
package mem_access_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam int IDX_W = 30;
    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_READ, RMW_WRITE, RESP} state_t;
endpackage

// File: rtl/lane_merge.sv
// lane_merge: little-endian lane insert for sub-word stores and lane extract/extend for loads.
module lane_merge
    import mem_access_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] extracted
);
    logic [31:0] mask;
    logic [31:0] shifted;
    logic [4:0]  sh;
    always_comb begin
        sh = {lane, 3'b000};
        mask = size == SIZE_BYTE ? 32'h0000_00FF : size == SIZE_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        merged = (old_word & ~(mask << sh)) | ((data & mask) << sh);
        shifted = old_word >> sh;
        extracted = size == SIZE_BYTE ? {{24{~is_unsigned & shifted[7]}}, shifted[7:0]}
                  : size == SIZE_HALF ? {{16{~is_unsigned & shifted[15]}}, shifted[15:0]}
                  : old_word;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding byte/half/word load-store initiator for a word-only memory.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_rnum,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_wnum,
    output logic [31:0] mem_wdata,
    output logic        mem_write
);
    state_t           state;
    logic [1:0]       size_q;
    logic [1:0]       lane_q;
    logic             uns_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [31:0]      merged;
    logic [31:0]      extracted;
    logic             req_err;

    always_comb begin
        req_err = req_size == 2'b11
               || (req_size == SIZE_HALF && req_addr[0])
               || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
               || {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
        req_ready = state == IDLE;
        resp_valid = state == RESP;
        mem_write = state == STORE || state == RMW_WRITE;
        mem_rnum = {2'b00, idx_q};
        mem_wnum = {2'b00, idx_q};
        mem_wdata = wdata_q;
    end

    lane_merge u_lane_merge (
        .old_word    (mem_rdata),
        .data        (wdata_q),
        .size        (size_q),
        .lane        (lane_q),
        .is_unsigned (uns_q),
        .merged      (merged),
        .extracted   (extracted)
    );

    // wdata_q doubles as the merged word once RMW_READ has sampled the old contents
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            size_q     <= SIZE_BYTE;
            lane_q     <= 2'b00;
            uns_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    size_q  <= req_size;
                    lane_q  <= req_addr[1:0];
                    uns_q   <= req_unsigned;
                    idx_q   <= req_addr[31:2];
                    wdata_q <= req_wdata;
                    if (req_err) begin
                        resp_error <= 1'b1;
                        resp_rdata <= '0;
                        state      <= RESP;
                    end else
                        state <= !req_write ? LOAD : req_size == SIZE_WORD ? STORE : RMW_READ;
                end
                LOAD: begin
                    resp_error <= 1'b0;
                    resp_rdata <= extracted;
                    state      <= RESP;
                end
                RMW_READ: begin
                    wdata_q <= merged;
                    state   <= RMW_WRITE;
                end
                STORE, RMW_WRITE: begin
                    resp_error <= 1'b0;
                    resp_rdata <= '0;
                    state      <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store vectors checked against a byte-lane memory model.
module tb_mem_access_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] mem_rnum;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wnum;
    logic [31:0] mem_wdata;
    logic        mem_write;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int acc_cnt = 0;
    int prev_acc = 0;
    int last_gap = 0;
    int resp_cnt = 0;
    int wr_cnt = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    bit          exp_pend = 1'b0;
    bit          exp_err;
    bit          exp_wr;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [5:0]  exp_widx;
    logic [31:0] exp_wword;

    mem_access_unit #(.MEM_WORDS(64)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_error(resp_error), .resp_rdata(resp_rdata), .mem_rnum(mem_rnum),
        .mem_rdata(mem_rdata), .mem_wnum(mem_wnum), .mem_wdata(mem_wdata), .mem_write(mem_write)
    );

    always #5 clock = ~clock;

    assign mem_rdata = (mem_rnum < 32'd64) ? mem[mem_rnum[5:0]] : 32'h0;
    always @(posedge clock) if (mem_write && mem_wnum < 32'd64) mem[mem_wnum[5:0]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clock) begin
        cyc++;
        if (reset_n && req_valid && req_ready) begin
            acc_cyc = cyc;
            if (acc_cnt > 0) last_gap = cyc - prev_acc;
            prev_acc = cyc;
            acc_cnt++;
        end
    end

    always @(negedge clock) if (reset_n) begin
        if (resp_valid) begin
            chk("resp_expected", 32'(exp_pend), 32'd1);
            chk("resp_error", 32'(resp_error), 32'(exp_err));
            chk("resp_rdata", resp_rdata, exp_rdata);
            chk("latency", 32'(cyc - acc_cyc + 1), 32'(exp_lat));
            last_rdata = resp_rdata;
            last_err = resp_error;
            resp_cnt++;
        end
        if (mem_write) begin
            chk("write_allowed", 32'(exp_wr), 32'd1);
            chk("mem_wnum", mem_wnum, 32'(exp_widx));
            chk("mem_wdata", mem_wdata, exp_wword);
            wr_cnt++;
        end
    end

    // Expected outcome from the access rules applied to the reference memory image
    task automatic model(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] old, mask, v;
        int sh;
        exp_err = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || a[31:2] >= 30'd64;
        exp_lat = exp_err ? 1 : (!w || sz == 2'd2) ? 2 : 3;
        exp_wr = !exp_err && w;
        exp_rdata = '0;
        exp_widx = '0;
        exp_wword = '0;
        if (!exp_err) begin
            exp_widx = a[7:2];
            old = ref_mem[a[7:2]];
            sh = 8 * int'(a[1:0]);
            mask = sz == 2'd0 ? 32'hFF : sz == 2'd1 ? 32'hFFFF : 32'hFFFF_FFFF;
            if (w) exp_wword = (old & ~(mask << sh)) | ((d & mask) << sh);
            else begin
                v = (old >> sh) & mask;
                if (!u && sz != 2'd2 && v > (mask >> 1)) v = v | ~mask;
                exp_rdata = v;
            end
        end
    endtask

    task automatic drive(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    endtask

    task automatic scramble;
        req_valid = 1'b0; req_write = ~req_write; req_size = ~req_size; req_addr = ~req_addr; req_wdata = $urandom;
    endtask

    task automatic issue(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a, input logic [31:0] d);
        int a0, r0, n;
        model(w, sz, u, a, d);
        exp_pend = 1'b1; wr_cnt = 0; a0 = acc_cnt; r0 = resp_cnt; n = 0;
        drive(w, sz, u, a, d);
        while (acc_cnt == a0 && n < 20) begin @(posedge clock); n++; end
        chk("accept_timeout", 32'(acc_cnt - a0), 32'd1);
        @(negedge clock);
        scramble();
        n = 0;
        while (resp_cnt == r0 && n < 10) begin @(negedge clock); n++; end
        chk("resp_timeout", 32'(resp_cnt - r0), 32'd1);
        chk("write_count", 32'(wr_cnt), 32'(exp_wr));
        if (exp_wr) begin
            chk("mem_word", mem[exp_widx], exp_wword);
            ref_mem[exp_widx] = exp_wword;
        end
        exp_pend = 1'b0;
    endtask

    task automatic b2b(input bit w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input int gap);
        int a0, r0, n;
        model(w, sz, 1'b0, a, d);
        exp_pend = 1'b1; a0 = acc_cnt; r0 = resp_cnt; n = 0;
        drive(w, sz, 1'b0, a, d);
        while (acc_cnt < a0 + 2 && n < 30) begin @(posedge clock); n++; end
        chk("b2b_accepts", 32'(acc_cnt - a0), 32'd2);
        chk("b2b_gap", 32'(last_gap), 32'(gap));
        @(negedge clock);
        scramble();
        n = 0;
        while (resp_cnt < r0 + 2 && n < 10) begin @(negedge clock); n++; end
        chk("b2b_resps", 32'(resp_cnt - r0), 32'd2);
        if (exp_wr) ref_mem[exp_widx] = exp_wword;
        exp_pend = 1'b0;
    endtask

    logic [1:0]  err_sz [4]  = '{2'd1, 2'd2, 2'd2, 2'd3};
    logic [31:0] err_a  [4]  = '{32'h11, 32'h12, 32'h100, 32'h0};
    bit          err_w  [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int n, r0;
        for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        repeat (2) @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_rnum", mem_rnum, 32'd0);
        chk("rst_mem_wnum", mem_wnum, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset_n = 1'b1;

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        chk("word_store_mem", mem[4], 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk("word_load", last_rdata, 32'hDEADBEEF);

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
        issue(1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFF_FFAA);
        chk("byte_store_mem", mem[4], 32'h11AA3344);
        issue(1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
        chk("byte_load_signed", last_rdata, 32'hFFFFFFAA);
        issue(1'b0, 2'd0, 1'b1, 32'h12, 32'h0);
        chk("byte_load_unsigned", last_rdata, 32'h000000AA);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        chk("byte_load_lane3", last_rdata, 32'h00000011);

        issue(1'b1, 2'd1, 1'b0, 32'h16, 32'h12348001);
        chk("half_store_mem", mem[5], 32'h80010000);
        issue(1'b0, 2'd1, 1'b0, 32'h16, 32'h0);
        chk("half_load_signed", last_rdata, 32'hFFFF8001);
        issue(1'b0, 2'd1, 1'b1, 32'h16, 32'h0);
        chk("half_load_unsigned", last_rdata, 32'h00008001);

        for (int i = 0; i < 4; i++) begin
            issue(err_w[i], err_sz[i], 1'b0, err_a[i], 32'hCAFEF00D);
            chk("error_flag", 32'(last_err), 32'd1);
        end
        chk("mem4_after_errors", mem[4], 32'h11AA3344);

        b2b(1'b0, 2'd2, 32'h10, 32'h0, 3);
        b2b(1'b1, 2'd0, 32'h14, 32'h55, 4);
        chk("b2b_byte_mem", mem[5], 32'h80010055);

        issue(1'b1, 2'd2, 1'b0, 32'h18, 32'h12345678);
        model(1'b1, 2'd0, 1'b0, 32'h19, 32'hAB);
        exp_pend = 1'b1; r0 = resp_cnt; n = 0;
        drive(1'b1, 2'd0, 1'b0, 32'h19, 32'hAB);
        @(negedge clock);
        scramble();
        while (!mem_write && n < 6) begin @(negedge clock); n++; end
        chk("rmw_write_seen", 32'(mem_write), 32'd1);
        reset_n = 1'b0;
        exp_pend = 1'b0;
        #1;
        chk("reset_drops_write", 32'(mem_write), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_mem_unchanged", mem[6], 32'h12345678);
        chk("reset_no_resp", 32'(resp_cnt - r0), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_resp_error", 32'(resp_error), 32'd0);
        issue(1'b0, 2'd2, 1'b0, 32'h18, 32'h0);
        chk("load_after_reset", last_rdata, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
